// File: rtl/uart_receive.sv
// UART receiver: synchronises the async line, samples each symbol once at a
// fixed offset from the start edge, and strobes the word or a framing error.
module uart_receive #(
  parameter int D_WIDTH      = 11,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam int OFF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT + 1);
  localparam int IW  = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_N    = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_OFF  = CW'(OFF);
  localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rx_s;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [D_WIDTH-1:0] shreg;
  logic               tick, at_off, last_bit;
  logic               take_bit, take_stop;

  // Synchroniser resets to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick     = (cnt == CNT_N);
  assign at_off   = (cnt == CNT_OFF);
  assign last_bit = (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // With OFF==0 the edge cycle doubles as the start sample, so START is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = (OFF == 0) ? DATA : START;
      START:   if (at_off) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && last_bit) state_nxt = STOP;
      STOP:    if (tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = 1'b0;
    take_bit  = 1'b0;
    take_stop = 1'b0;
    case (state)
      START: rx_busy = 1'b1;
      DATA: begin
        rx_busy  = 1'b1;
        take_bit = tick;
      end
      STOP: begin
        rx_busy   = 1'b1;
        take_stop = tick;
      end
      default: ;
    endcase
  end

  // cnt holds cycles since the last sample point; it restarts at 1 on each sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_ONE;
      idx      <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= take_stop && rx_s;
      rx_err   <= take_stop && !rx_s;
      if (take_stop) rx_data <= shreg;
      if (take_bit)  shreg[idx] <= rx_s;

      case (state)
        START:       cnt <= at_off ? CNT_ONE : cnt + CNT_ONE;
        DATA, STOP:  cnt <= tick ? CNT_ONE : cnt + CNT_ONE;
        default:     cnt <= CNT_ONE;
      endcase

      if (state == IDLE)  idx <= '0;
      else if (take_bit)  idx <= last_bit ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: one instance at 1 clk/bit, one at 4 clk/bit, checked
// every cycle against an edge-indexed expectation schedule built from frame timing.
module tb_uart_receive;
  localparam int D    = 11;
  localparam int S    = 2;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst, rx0, rx1;
  logic [D-1:0] data0, data1;
  logic valid0, valid1, err0, err1, busy0, busy1;

  uart_receive #(.D_WIDTH(D), .CLKS_PER_BIT(1), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .rx(rx0),
    .rx_data(data0), .rx_valid(valid0), .rx_err(err0), .rx_busy(busy0));

  uart_receive #(.D_WIDTH(D), .CLKS_PER_BIT(4), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst(rst), .rx(rx1),
    .rx_data(data1), .rx_valid(valid1), .rx_err(err1), .rx_busy(busy1));

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] data;
    bit           ok;
    int           hold;
    int           gap;
    logic [D-1:0] x_data;
    bit           x_valid;
    bit           x_err;
  } vec_t;

  typedef struct {
    logic [D-1:0] d;
    logic         v;
    logic         e;
  } obs_t;

  int n_cmp = 0, n_bad = 0, edge_no = 0;
  bit xv[2][MAXE], xe[2][MAXE], xb[2][MAXE], xl[2][MAXE];
  logic [D-1:0] xd[2][MAXE];
  logic [D-1:0] hold[2];
  obs_t obs_q[$];
  vec_t tab[8];

  function automatic int nbit(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @edge %0d: got %0h, want %0h", nm, i, edge_no, act, exp);
    end
  endtask

  // Expected frame: busy from the start edge (after S sync edges) until the
  // stop sample, then a one-cycle pulse carrying the word.
  task automatic schedule(input int i, input int e0, input logic [D-1:0] d, input bit ok);
    int n, off, p;
    n = nbit(i); off = (n - 1) / 2;
    p = e0 + S + off + n * (D + 1);
    if (p >= MAXE) begin
      $display("FAIL edge_budget[%0d]: %0d beyond %0d", i, p, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    for (int e = e0 + S; e < p; e++) xb[i][e] = 1'b1;
    xv[i][p] = ok; xe[i][p] = !ok; xl[i][p] = 1'b1; xd[i][p] = d;
  endtask

  task automatic check_dut(input int i, input int e, input logic [D-1:0] d,
                           input logic v, input logic er, input logic bz);
    if (xl[i][e]) hold[i] = xd[i][e];
    chk("valid", i, 32'(v),  32'(xv[i][e]));
    chk("err",   i, 32'(er), 32'(xe[i][e]));
    chk("busy",  i, 32'(bz), 32'(xb[i][e]));
    chk("data",  i, 32'(d),  32'(hold[i]));
  endtask

  task automatic step(input logic a0, input logic a1);
    int e;
    rx0 = a0; rx1 = a1;
    @(posedge clk); #1;
    e = edge_no;
    if (e >= MAXE) begin
      $display("FAIL edge_budget: edge %0d", e);
      $fatal(1, "edge budget exhausted");
    end
    check_dut(0, e, data0, valid0, err0, busy0);
    check_dut(1, e, data1, valid1, err1, busy1);
    if (valid0 || err0) obs_q.push_back('{d: data0, v: valid0, e: err0});
    edge_no++;
  endtask

  task automatic line(input int i, input logic b);
    if (i == 0) step(b, 1'b1);
    else        step(1'b1, b);
  endtask

  task automatic idle(input int c);
    repeat (c) step(1'b1, 1'b1);
  endtask

  task automatic do_reset(input int c);
    for (int i = 0; i < 2; i++) begin
      for (int e = edge_no; e < MAXE; e++) begin
        xv[i][e] = 1'b0; xe[i][e] = 1'b0; xb[i][e] = 1'b0; xl[i][e] = 1'b0;
      end
      hold[i] = '0;
    end
    rst = 1'b1;
    idle(c);
    rst = 1'b0;
  endtask

  // hold: cycles the line stays low from the stop slot on a bad frame (>= N)
  task automatic send(input int i, input logic [D-1:0] d, input bit ok, input int hold_lo);
    int n;
    n = nbit(i);
    schedule(i, edge_no, d, ok);
    for (int c = 0; c < n; c++) line(i, 1'b0);
    for (int b = 0; b < D; b++)
      for (int c = 0; c < n; c++) line(i, d[b]);
    if (ok) for (int c = 0; c < n; c++) line(i, 1'b1);
    else    for (int c = 0; c < hold_lo; c++) line(i, 1'b0);
  endtask

  task automatic glitch(input int i);
    int off;
    off = (nbit(i) - 1) / 2;
    for (int e = edge_no + S; e < edge_no + S + off; e++) xb[i][e] = 1'b1;
    line(i, 1'b0);
  endtask

  task automatic run_random(input int i, input int nfr);
    int n;
    logic [D-1:0] d;
    bit ok;
    n = nbit(i);
    for (int k = 0; k < nfr; k++) begin
      d  = D'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      if (i == 1 && $urandom_range(0, 2) == 0) begin
        glitch(1);
        idle($urandom_range(1, 3));
      end
      send(i, d, ok, n + $urandom_range(0, 8));
      idle(ok ? $urandom_range(0, 3) : $urandom_range(1, 3));
    end
    idle(n * 2 + 6);
  endtask

  initial begin
    logic [D-1:0] abort_d;
    tab[0] = '{11'h5A3, 1'b1, 0,  4, 11'h5A3, 1'b1, 1'b0};
    tab[1] = '{11'h7FF, 1'b1, 0,  0, 11'h7FF, 1'b1, 1'b0};
    tab[2] = '{11'h001, 1'b1, 0,  3, 11'h001, 1'b1, 1'b0};
    tab[3] = '{11'h2AA, 1'b0, 20, 2, 11'h2AA, 1'b0, 1'b1};
    tab[4] = '{11'h3C5, 1'b1, 0,  2, 11'h3C5, 1'b1, 1'b0};
    tab[5] = '{11'h000, 1'b1, 0,  0, 11'h000, 1'b1, 1'b0};
    tab[6] = '{11'h400, 1'b0, 1,  1, 11'h400, 1'b0, 1'b1};
    tab[7] = '{11'h555, 1'b1, 0,  5, 11'h555, 1'b1, 1'b0};

    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    do_reset(3);
    idle(50);

    obs_q.delete();
    for (int k = 0; k < 8; k++) begin
      send(0, tab[k].data, tab[k].ok, tab[k].hold);
      idle(tab[k].gap);
    end
    idle(6);
    chk("table_pulses", 0, 32'(obs_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      chk("table_data",  k, 32'(obs_q[k].d), 32'(tab[k].x_data));
      chk("table_valid", k, 32'(obs_q[k].v), 32'(tab[k].x_valid));
      chk("table_err",   k, 32'(obs_q[k].e), 32'(tab[k].x_err));
    end

    glitch(1);
    idle(6);
    send(1, 11'h155, 1'b1, 0);
    idle(8);
    chk("n4_data", 1, 32'(data1), 32'h155);

    abort_d = 11'h3CF;
    schedule(0, edge_no, abort_d, 1'b1);
    line(0, 1'b0);
    for (int b = 0; b < 5; b++) line(0, abort_d[b]);
    do_reset(2);
    chk("abort_data", 0, 32'(data0), 32'h0);
    idle(20);
    send(0, 11'h0F0, 1'b1, 0);
    idle(5);
    chk("post_reset_data", 0, 32'(data0), 32'h0F0);

    run_random(0, 30);
    run_random(1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
